// File: rtl/store_align_unit_pkg.sv
// Shared definitions for the store alignment path: memop encodings, the
// store FSM state type and the memop-to-size helper.
package store_align_unit_pkg;

  localparam int BUS_BYTES = 8;

  // Memop codes carried with a store request from the MEM stage.
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_D  = 3'b011;
  localparam logic [2:0] MEM_UB = 3'b100;
  localparam logic [2:0] MEM_UH = 3'b101;
  localparam logic [2:0] MEM_UW = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_LO = 3'd1,
    ST_ACK_LO = 3'd2,
    ST_REQ_HI = 3'd3,
    ST_ACK_HI = 3'd4,
    ST_DONE   = 3'd5,
    ST_FAULT  = 3'd6
  } store_state_e;

  // Byte count of a store memop; zero marks an unsupported code.
  function automatic logic [3:0] memop_size(input logic [2:0] memop);
    logic [3:0] size;
    case (memop)
      MEM_B, MEM_UB: size = 4'd1;
      MEM_H, MEM_UH: size = 4'd2;
      MEM_W, MEM_UW: size = 4'd4;
      MEM_D:         size = 4'd8;
      default:       size = 4'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/store_align_unit_lane_gen.sv
// store_lane_gen: purely combinational lane placement of one store.
// Produces the 16-byte-window byte mask and data, plus crossing/invalid
// flags, from the low address bits, register data and memop. Kept free of
// state so it can also serve store-to-load forwarding checks.
module store_lane_gen
  import store_align_unit_pkg::*;
(
  input  logic [2:0]   i_offset,
  input  logic [63:0]  i_data,
  input  logic [2:0]   i_memop,
  output logic [15:0]  o_mask16,
  output logic [127:0] o_data128,
  output logic         o_crossing,
  output logic         o_invalid
);

  logic [3:0]   w_size;
  logic [63:0]  w_keep;
  logic [127:0] w_data_wide;

  // Trim data to the access size, then shift bytes and mask into their lanes.
  always_comb begin
    w_size = memop_size(i_memop);
    w_keep = 64'd0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      if (4'(i) < w_size) begin
        w_keep[i*8 +: 8] = 8'hFF;
      end else begin
        w_keep[i*8 +: 8] = 8'h00;
      end
    end
    o_mask16    = ((16'd1 << w_size) - 16'd1) << i_offset;
    w_data_wide = {64'd0, i_data & w_keep};
    o_data128   = w_data_wide << {i_offset, 3'b000};
    o_invalid   = (w_size == 4'd0);
    o_crossing  = (o_mask16[15:8] != 8'd0);
  end

endmodule

// File: rtl/store_align_unit.sv
// store_align_unit: accepts one store from the MEM stage, places it on the
// doubleword-aligned data-memory bus and runs the valid/ready + ack
// handshake, reporting completion or fault back to the pipeline.
// Optional feature macro: STORE_MISALIGN_SPLIT_EN -- when defined, stores
// that straddle a doubleword boundary are issued as two beats (lo, hi);
// when undefined such stores are rejected with a fault.
// All outputs are registered; they are loaded from the next-state decode.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [2:0]        st_memop,
  output logic              st_done,
  output logic              st_fault,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_ack
);

`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  store_state_e      r_state;
  store_state_e      w_next_state;
  logic              w_load_lo;
  logic              w_load_hi;

  logic [15:0]       w_mask16;
  logic [127:0]      w_data128;
  logic              w_crossing;
  logic              w_invalid;
  logic [ADDR_W-1:0] w_lo_addr;
  logic [ADDR_W-1:0] w_hi_addr;

  logic              r_crossing;
  logic [ADDR_W-1:0] r_hi_addr;
  logic [7:0]        r_hi_mask;
  logic [DATA_W-1:0] r_hi_data;

  logic              r_st_ready;
  logic              r_st_done;
  logic              r_st_fault;
  logic              r_mem_req_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [7:0]        r_mem_wmask;

  store_lane_gen u_lane_gen (
    .i_offset   (st_addr[2:0]),
    .i_data     (st_data),
    .i_memop    (st_memop),
    .o_mask16   (w_mask16),
    .o_data128  (w_data128),
    .o_crossing (w_crossing),
    .o_invalid  (w_invalid)
  );

  // The hi beat addresses the next doubleword; the add wraps at the top.
  assign w_lo_addr = {st_addr[ADDR_W-1:3], 3'b000};
  assign w_hi_addr = w_lo_addr + 64'd8;

  // Next-state decode plus strobes that load the lo/hi beat payload.
  always_comb begin
    w_next_state = r_state;
    w_load_lo    = 1'b0;
    w_load_hi    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (st_valid) begin
          if (w_invalid || (w_crossing && !SPLIT_EN)) begin
            w_next_state = ST_FAULT;
          end else begin
            w_next_state = ST_REQ_LO;
            w_load_lo    = 1'b1;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REQ_LO: begin
        if (mem_req_ready) begin
          w_next_state = ST_ACK_LO;
        end else begin
          w_next_state = ST_REQ_LO;
        end
      end
      ST_ACK_LO: begin
        if (mem_ack) begin
          if (r_crossing && SPLIT_EN) begin
            w_next_state = ST_REQ_HI;
            w_load_hi    = 1'b1;
          end else begin
            w_next_state = ST_DONE;
          end
        end else begin
          w_next_state = ST_ACK_LO;
        end
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      ST_REQ_HI: begin
        if (mem_req_ready) begin
          w_next_state = ST_ACK_HI;
        end else begin
          w_next_state = ST_REQ_HI;
        end
      end
      ST_ACK_HI: begin
        if (mem_ack) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_ACK_HI;
        end
      end
`endif
      ST_DONE:  w_next_state = ST_IDLE;
      ST_FAULT: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_st_ready      <= 1'b1;
      r_st_done       <= 1'b0;
      r_st_fault      <= 1'b0;
      r_mem_req_valid <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_st_ready      <= (w_next_state == ST_IDLE);
      r_st_done       <= (w_next_state == ST_DONE) || (w_next_state == ST_FAULT);
      r_st_fault      <= (w_next_state == ST_FAULT);
      r_mem_req_valid <= (w_next_state == ST_REQ_LO) || (w_next_state == ST_REQ_HI);
    end
  end

  // Bus payload: loaded only on entry to a request state so it stays
  // constant for as long as mem_req_valid is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= 8'd0;
      r_crossing  <= 1'b0;
      r_hi_addr   <= '0;
      r_hi_mask   <= 8'd0;
      r_hi_data   <= '0;
    end else if (w_load_lo) begin
      r_mem_addr  <= w_lo_addr;
      r_mem_wdata <= w_data128[63:0];
      r_mem_wmask <= w_mask16[7:0];
      r_crossing  <= w_crossing;
      r_hi_addr   <= w_hi_addr;
      r_hi_mask   <= w_mask16[15:8];
      r_hi_data   <= w_data128[127:64];
    end else if (w_load_hi) begin
      r_mem_addr  <= r_hi_addr;
      r_mem_wdata <= r_hi_data;
      r_mem_wmask <= r_hi_mask;
    end else begin
      r_mem_addr  <= r_mem_addr;
      r_mem_wdata <= r_mem_wdata;
      r_mem_wmask <= r_mem_wmask;
    end
  end

  assign st_ready      = r_st_ready;
  assign st_done       = r_st_done;
  assign st_fault      = r_st_fault;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wmask     = r_mem_wmask;

endmodule
